// File: rtl/tile_pkg.sv
// Shared types and constants for the tile RAM writer: command encodings, FSM state,
// RAM widths and the packed command record held in the command FIFO.
package tile_pkg;

  localparam int unsigned RAM_AW = 16;
  localparam int unsigned RAM_DW = 16;
  localparam int unsigned CNT_W  = 8;

  localparam logic CMD_WRITE = 1'b0;
  localparam logic CMD_FILL  = 1'b1;

  typedef enum logic {
    StIdle = 1'b0,
    StFill = 1'b1
  } state_e;

  typedef struct packed {
    logic              cmd;
    logic [RAM_AW-1:0] addr;
    logic [RAM_DW-1:0] data;
    logic [CNT_W-1:0]  count;
  } tile_cmd_t;

endpackage

// File: rtl/tile_ram_writer_if.sv
// CPU command port and RAM write port of the tile RAM writer, bundled as one interface.
interface tile_ram_writer_if;
  import tile_pkg::*;

  logic              cpu_valid;
  logic              cpu_ready;
  logic              cpu_cmd;
  logic [RAM_AW-1:0] cpu_addr;
  logic [RAM_DW-1:0] cpu_data;
  logic [CNT_W-1:0]  cpu_count;
  logic              ram_busy;
  logic [RAM_AW-1:0] ram_addr;
  logic [RAM_DW-1:0] ram_write;
  logic              ram_we;
  logic              idle;

  modport master (
    output cpu_valid, cpu_cmd, cpu_addr, cpu_data, cpu_count, ram_busy,
    input  cpu_ready, ram_addr, ram_write, ram_we, idle
  );

  modport slave (
    input  cpu_valid, cpu_cmd, cpu_addr, cpu_data, cpu_count, ram_busy,
    output cpu_ready, ram_addr, ram_write, ram_we, idle
  );

endinterface

// File: rtl/tile_cmd_fifo.sv
// Command FIFO for the tile RAM writer; DEPTH must be a power of two (>= 2).
// Head entry is presented combinationally on rdata.
module tile_cmd_fifo
  import tile_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      push,
  input  logic      pop,
  input  tile_cmd_t wdata,
  output tile_cmd_t rdata,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] PtrOne = 1;

  tile_cmd_t   mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        do_push, do_pop;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/tile_ram_writer.sv
// Queues CPU cell writes / fills and streams them into tile RAM around renderer busy cycles.
// Fill engine is built only when TILE_FILL_EN is defined; otherwise every command is a single write.
module tile_ram_writer
  import tile_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              reset,
  tile_ram_writer_if.slave bus
);

  tile_cmd_t         wdata, head;
  logic              full, empty, push, pop;
  logic              ready_q;
  logic              ram_we_q, ram_we_d;
  logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
  logic [RAM_DW-1:0] ram_write_q, ram_write_d;
  logic              st_idle;

  // ready_q keeps cpu_ready low through reset and for the first edge after release.
  assign bus.cpu_ready = ready_q & ~full;
  assign push          = bus.cpu_valid & bus.cpu_ready;
  assign wdata         = '{cmd: bus.cpu_cmd, addr: bus.cpu_addr, data: bus.cpu_data,
                           count: bus.cpu_count};

  tile_cmd_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .wdata(wdata),
    .rdata(head),
    .full (full),
    .empty(empty)
  );

`ifdef TILE_FILL_EN
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign st_idle = (state_q == StIdle);

  always_comb begin
    pop         = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_write_d = ram_write_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (!bus.ram_busy) begin
      unique case (state_q)
        StIdle: begin
          if (!empty) begin
            pop         = 1'b1;
            ram_we_d    = 1'b1;
            ram_addr_d  = head.addr;
            ram_write_d = head.data;
            // cnt_q counts words still to issue; count 0 wraps to 255 remaining (256 total).
            if (head.cmd == CMD_FILL && head.count != 8'd1) begin
              state_d = StFill;
              cnt_d   = head.count - 8'd1;
            end
          end
        end
        StFill: begin
          ram_we_d   = 1'b1;
          ram_addr_d = ram_addr_q + 16'd1;
          cnt_d      = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = StIdle;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  logic unused_fill;

  assign st_idle     = 1'b1;
  assign unused_fill = ^{head.cmd, head.count};

  always_comb begin
    pop         = 1'b0;
    ram_we_d    = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_write_d = ram_write_q;
    if (!bus.ram_busy && !empty) begin
      pop         = 1'b1;
      ram_we_d    = 1'b1;
      ram_addr_d  = head.addr;
      ram_write_d = head.data;
    end
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ready_q     <= 1'b0;
      ram_we_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_write_q <= '0;
    end else begin
      ready_q     <= 1'b1;
      ram_we_q    <= ram_we_d;
      ram_addr_q  <= ram_addr_d;
      ram_write_q <= ram_write_d;
    end
  end

  assign bus.ram_we    = ram_we_q;
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_write = ram_write_q;
  assign bus.idle      = empty & st_idle & ~ram_we_q;

endmodule

// File: tb/tb_tile_ram_writer.sv
// Scoreboard bench for tile_ram_writer: stimulus pushes expected RAM writes (address, data,
// cycle) into a queue; a negedge monitor pops and compares on every ram_we cycle.
module tb_tile_ram_writer;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   n_writes = 0;
  int   n_expected = 0;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];

  tile_ram_writer_if bus ();

  tile_ram_writer #(
    .FIFO_DEPTH(4)
  ) dut (
    .clk  (clk),
    .reset(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.ram_we === 1'b1) begin
      n_writes++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL write_unexpected: got addr=%h data=%h cyc=%0d, required no write",
                 bus.ram_addr, bus.ram_write, cyc);
      end else begin
        e = exp_q.pop_front();
        if (bus.ram_addr !== e.addr || bus.ram_write !== e.data || (e.cyc >= 0 && cyc != e.cyc))
        begin
          miscompares++;
          $display("FAIL write_word: got addr=%h data=%h cyc=%0d, required addr=%h data=%h cyc=%0d",
                   bus.ram_addr, bus.ram_write, cyc, e.addr, e.data, e.cyc);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  task automatic expect_write(input logic [15:0] addr, input logic [15:0] data, input int c);
    exp_t e;
    e.addr = addr;
    e.data = data;
    e.cyc  = c;
    exp_q.push_back(e);
    n_expected++;
  endtask

  // Returns the cycle number of the accepting edge in acc (-1 if never accepted).
  task automatic send(input logic cmd, input logic [15:0] addr, input logic [15:0] data,
                      input logic [7:0] count, output int acc);
    int n = 0;
    bus.cpu_valid = 1'b1;
    bus.cpu_cmd   = cmd;
    bus.cpu_addr  = addr;
    bus.cpu_data  = data;
    bus.cpu_count = count;
    while (bus.cpu_ready !== 1'b1 && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) begin
      vectors++;
      miscompares++;
      $display("FAIL send_timeout: got cpu_ready=%b, required 1 within 500 cycles", bus.cpu_ready);
      acc = -1;
    end else begin
      @(posedge clk);
      #1;
      acc = cyc;
    end
    bus.cpu_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.idle !== 1'b1 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) begin
      vectors++;
      miscompares++;
      $display("FAIL idle_timeout: got idle=%b, required 1 within 2000 cycles", bus.idle);
    end
  endtask

  // Expected writes of one command accepted at cycle acc with no busy cycles.
  task automatic expect_cmd(input logic cmd, input logic [15:0] addr, input logic [15:0] data,
                            input int words, input int acc);
`ifdef TILE_FILL_EN
    if (cmd == 1'b1) begin
      for (int i = 0; i < words; i++) expect_write(addr + 16'(i), data, acc + 1 + i);
    end else begin
      expect_write(addr, data, acc + 1);
    end
`else
    expect_write(addr, data, acc + 1);
`endif
  endtask

  initial begin
    int a, b;
    rst_n         = 1'b0;
    bus.cpu_valid = 1'b0;
    bus.cpu_cmd   = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    bus.cpu_count = '0;
    bus.ram_busy  = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_we", 32'(bus.ram_we), 32'd0);
    check("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    check("rst_ram_write", 32'(bus.ram_write), 32'd0);
    check("rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
    check("rst_idle", 32'(bus.idle), 32'd1);
    rst_n = 1'b1;
    #1;
    check("ready_before_edge", 32'(bus.cpu_ready), 32'd0);
    @(posedge clk);
    #1;
    check("ready_after_edge", 32'(bus.cpu_ready), 32'd1);

    // Single write, one-cycle latency, then idle
    send(1'b0, 16'h7E05, 16'h1F41, 8'd0, a);
    expect_cmd(1'b0, 16'h7E05, 16'h1F41, 1, a);
    @(posedge clk);
    #1;
    check("single_not_idle", 32'(bus.idle), 32'd0);
    @(posedge clk);
    #1;
    check("single_idle_after", 32'(bus.idle), 32'd1);

    // Fill of 32 words
    send(1'b1, 16'h0400, 16'h0020, 8'd32, a);
    expect_cmd(1'b1, 16'h0400, 16'h0020, 32, a);
    wait_idle();

    // Busy stall of 42 cycles after word 10
    send(1'b1, 16'h0400, 16'h0020, 8'd32, a);
`ifdef TILE_FILL_EN
    for (int i = 0; i < 32; i++)
      expect_write(16'h0400 + 16'(i), 16'h0020, (i < 10) ? a + 1 + i : a + 43 + i);
`else
    expect_write(16'h0400, 16'h0020, a + 1);
`endif
    repeat (10) @(posedge clk);
    #1;
    bus.ram_busy = 1'b1;
    repeat (42) @(posedge clk);
    #1;
    bus.ram_busy = 1'b0;
    wait_idle();

    // FIFO full while busy, then drain in push order
    bus.ram_busy = 1'b1;
    for (int i = 0; i < 4; i++) send(1'b0, 16'h1000 + 16'(i), 16'hA000 + 16'(i), 8'd0, b);
    check("full_ready_low", 32'(bus.cpu_ready), 32'd0);
    bus.ram_busy = 1'b0;
    for (int i = 0; i < 4; i++) expect_write(16'h1000 + 16'(i), 16'hA000 + 16'(i), b + 1 + i);
    @(posedge clk);
    #1;
    check("ready_after_pop", 32'(bus.cpu_ready), 32'd1);
    wait_idle();

    // Address wrap with count 0 (256 words)
    send(1'b1, 16'hFFFE, 16'h5A5A, 8'd0, a);
    expect_cmd(1'b1, 16'hFFFE, 16'h5A5A, 256, a);
    wait_idle();

    // Fill followed back-to-back by a single write: no gap
    send(1'b1, 16'h3000, 16'h0C0C, 8'd3, a);
    send(1'b0, 16'h4000, 16'hBEEF, 8'd0, b);
`ifdef TILE_FILL_EN
    expect_cmd(1'b1, 16'h3000, 16'h0C0C, 3, a);
    expect_write(16'h4000, 16'hBEEF, a + 4);
`else
    expect_write(16'h3000, 16'h0C0C, a + 1);
    expect_write(16'h4000, 16'hBEEF, a + 2);
`endif
    wait_idle();

    // Reset in the middle of a fill discards the rest
    send(1'b1, 16'h2000, 16'h1234, 8'd20, a);
    expect_cmd(1'b1, 16'h2000, 16'h1234, 5, a);
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midfill_rst_we", 32'(bus.ram_we), 32'd0);
    check("midfill_rst_addr", 32'(bus.ram_addr), 32'd0);
    check("midfill_rst_idle", 32'(bus.idle), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("post_rst_idle", 32'(bus.idle), 32'd1);

    // Scoreboard drained, no lost or duplicated words
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("total_writes", 32'(n_writes), 32'(n_expected));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
